change_dispenser_ctrl: RTL and testbench
========================================

Name: change_dispenser_ctrl

Overview:
Sequences the coin hopper that returns change after a vending purchase. The purchase FSM computes change (e.g. 26 inserted minus coffee 20 = 6). It hands that amount over with a start pulse. This block then issues coins greedily (10, then 5, then 1), one coin per hopper handshake, and tracks per-denomination inventory. If inventory cannot cover the full amount, it reports the shortfall instead of hanging.

Parameters:
CNT_W, 8, width of each denomination inventory counter
INIT_CNT10, 8, 10-dollar coins loaded at reset
INIT_CNT5, 8, 5-dollar coins loaded at reset
INIT_CNT1, 8, 1-dollar coins loaded at reset

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request to return change; sampled only in IDLE
amount  input  8  change amount in dollars, captured when start is accepted
hopper_ready  input  1  hopper accepts the presented coin this cycle
refill  input  1  add one coin of denomination refill_sel to inventory
refill_sel  input  2  0 = 1-dollar, 1 = 5-dollar, 2 = 10-dollar, 3 = ignored
coin_valid  output  1  a coin is presented to the hopper
coin_value  output  8  denomination presented: 10, 5 or 1; 0 when coin_valid = 0
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when a request finishes
short  output  1  valid with done: 1 = change could not be fully paid
short_amt  output  8  valid with done: unpaid remainder; 0 when short = 0
inv_empty  output  3  {10, 5, 1} inventory counters equal to zero

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: state = IDLE; remaining = 0; coin_valid = 0; coin_value = 0; busy = 0; done = 0; short = 0; short_amt = 0.
- Reset also loads the inventory counters from the INIT_CNT* parameters.
- Reset during any state, including mid-handshake, aborts the request immediately. No done pulse is produced.

State machine:
- IDLE:
  - On start: capture remaining = amount and go to SELECT.
  - start is ignored while busy, with no queuing.
- SELECT (one cycle):
  - If remaining == 0: go to DONE with short = 0.
  - Otherwise pick the largest d in {10, 5, 1} where d <= remaining and cnt_d > 0. Latch it as cur_d and go to DISPENSE.
  - If no d qualifies: go to DONE with short = 1 and short_amt = remaining.
- DISPENSE:
  - coin_valid = 1 and coin_value = cur_d, both held stable until hopper_ready.
  - In the cycle where coin_valid & hopper_ready: remaining -= cur_d, cnt_cur_d -= 1, then go to SELECT.
- DONE (one cycle): done = 1, short and short_amt valid, then go to IDLE. short and short_amt hold their value until the next start is accepted.

Timing:
- start at cycle T gives SELECT at T+1 and the first coin_valid at T+2.
- With hopper_ready tied high, each coin costs 2 cycles.
- amount = 0 gives done at T+2.
- Total duration for N coins = 2N+2 cycles from start to done.

Arithmetic and inventory:
- remaining is 8-bit unsigned and never underflows, because d <= remaining is checked before selection.
- Inventory counters saturate at 2^CNT_W-1 on refill.
- Refill is accepted in any state.
- Refill and dispense of the same denomination in the same cycle give a net-zero change to the count.
- A refill arriving during DISPENSE does not alter cur_d. It is seen at the next SELECT.

Decomposition:
- Shared package vending_pkg holds:
  - coin constants COIN_1 = 1, COIN_5 = 5, COIN_10 = 10;
  - drink prices TEA = 10, COKE = 15, COFFEE = 20, MILK = 25;
  - drink codes 0..3;
  - the state encoding for IDLE/SELECT/DISPENSE/DONE.
- One sub-module, coin_inventory_counter: a saturating up/down counter with a parameterized init value and a zero flag. It is instantiated three times.

Test Plan:
- Defaults, amount = 6, start, hopper_ready = 1 -> coins 5 then 1. done at start+6 with short = 0 and short_amt = 0. cnt5 = 7, cnt1 = 7.
- amount = 26 -> coin_value sequence 10, 10, 5, 1. done with short = 0. cnt10 = 6.
- amount = 6, hopper_ready held low 3 cycles on the first coin -> coin_valid stays 1 and coin_value stays 5 for all 4 cycles. Only one decrement occurs.
- INIT_CNT5 = 0, amount = 7 -> seven 1-dollar coins. INIT_CNT1 = 0, amount = 3 -> no coin issued; done with short = 1 and short_amt = 3.
- Reset asserted during DISPENSE of amount = 15 -> next cycle coin_valid = 0, busy = 0, no done pulse. Counters return to 8.
- refill (refill_sel = 2) in the same cycle a 10-coin handshake completes -> cnt10 unchanged. A start arriving while busy is ignored.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared vending-machine definitions: coin denominations, drink codes and
// prices, refill selector codes and the change-dispenser state encoding.
// No ports; imported by the change dispenser and its bench.
package vending_pkg;

   // Coin denominations in dollars, sized to match the 8-bit money datapath.
   localparam logic [7:0] COIN_1  = 8'd1;
   localparam logic [7:0] COIN_5  = 8'd5;
   localparam logic [7:0] COIN_10 = 8'd10;

   // Drink prices in dollars.
   localparam logic [7:0] TEA    = 8'd10;
   localparam logic [7:0] COKE   = 8'd15;
   localparam logic [7:0] COFFEE = 8'd20;
   localparam logic [7:0] MILK   = 8'd25;

   typedef enum logic [1:0] {
      DRINK_TEA    = 2'd0,
      DRINK_COKE   = 2'd1,
      DRINK_COFFEE = 2'd2,
      DRINK_MILK   = 2'd3
   } drink_e;

   // Refill selector codes; code 3 is ignored.
   localparam logic [1:0] REFILL_1  = 2'd0;
   localparam logic [1:0] REFILL_5  = 2'd1;
   localparam logic [1:0] REFILL_10 = 2'd2;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SELECT   = 2'd1,
      DISPENSE = 2'd2,
      DONE     = 2'd3
   } disp_state_e;

   function automatic logic [7:0] drink_price(input drink_e drink);
      case (drink)
         DRINK_TEA:    drink_price = TEA;
         DRINK_COKE:   drink_price = COKE;
         DRINK_COFFEE: drink_price = COFFEE;
         default:      drink_price = MILK;
      endcase
   endfunction

endpackage

// File: rtl/change_dispenser_ctrl_if.sv
// Bundle between the purchase FSM / hopper / refill logic (master) and the
// change dispenser (slave).
//   start, amount          : change request, amount in dollars
//   hopper_ready           : hopper takes the presented coin this cycle
//   refill, refill_sel     : add one coin of the selected denomination
//   coin_valid, coin_value : coin presented to the hopper
//   busy, done             : request in flight / one-cycle completion pulse
//   short, short_amt       : shortfall flag and unpaid remainder
//   inv_empty              : {10, 5, 1} inventory counters at zero
interface change_dispenser_ctrl_if;

   logic       start;
   logic [7:0] amount;
   logic       hopper_ready;
   logic       refill;
   logic [1:0] refill_sel;
   logic       coin_valid;
   logic [7:0] coin_value;
   logic       busy;
   logic       done;
   logic       short;
   logic [7:0] short_amt;
   logic [2:0] inv_empty;

   modport master (
      output start, amount, hopper_ready, refill, refill_sel,
      input  coin_valid, coin_value, busy, done, short, short_amt, inv_empty
   );

   modport slave (
      input  start, amount, hopper_ready, refill, refill_sel,
      output coin_valid, coin_value, busy, done, short, short_amt, inv_empty
   );

endinterface

// File: rtl/coin_inventory_counter.sv
// Per-denomination coin inventory: saturating up/down counter loaded with
// INIT on reset.
//   clk, reset : clock, synchronous active-high reset
//   inc_i      : one coin refilled (saturates at all-ones)
//   dec_i      : one coin dispensed (never below zero)
//   count_o    : current coin count
//   zero_o     : count_o is zero
module coin_inventory_counter #(
   parameter int CNT_W = 8,
   parameter int INIT  = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc_i,
   input  logic             dec_i,
   output logic [CNT_W-1:0] count_o,
   output logic             zero_o
);

   localparam logic [CNT_W-1:0] MAX_V  = '1;
   localparam logic [CNT_W-1:0] INIT_V = CNT_W'(INIT);

   logic [CNT_W-1:0] count_q, count_d;

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge value, independent of process ordering.
   always_ff @(posedge clk) begin
      if (reset) count_q <= INIT_V;
      else       count_q <= count_d;
   end

   // NOTE: the default is assigned first so no path leaves count_d
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      count_d = count_q;
      // A simultaneous refill and dispense cancels out.
      case ({inc_i, dec_i})
         2'b10:   if (count_q != MAX_V) count_d = count_q + 1'b1;
         2'b01:   if (count_q != '0)    count_d = count_q - 1'b1;
         default: ;
      endcase
   end

   assign count_o = count_q;
   assign zero_o  = (count_q == '0);

endmodule

// File: rtl/change_dispenser_ctrl.sv
// Change dispenser: pays out a requested amount greedily (10, 5, 1), one coin
// per hopper handshake, and reports any shortfall when inventory runs out.
//   clk, reset : clock, synchronous active-high reset (aborts any request)
//   bus        : slave side of change_dispenser_ctrl_if (request, hopper,
//                refill, status and inventory-empty flags)
module change_dispenser_ctrl
   import vending_pkg::*;
#(
   parameter int CNT_W      = 8,
   parameter int INIT_CNT10 = 8,
   parameter int INIT_CNT5  = 8,
   parameter int INIT_CNT1  = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   change_dispenser_ctrl_if.slave  bus
);

   disp_state_e state_q, state_d;
   logic [7:0]  remaining_q, remaining_d;
   logic [7:0]  cur_d_q, cur_d_d;
   logic        short_q, short_d;
   logic [7:0]  short_amt_q, short_amt_d;

   logic [CNT_W-1:0] cnt10, cnt5, cnt1;
   logic             zero10, zero5, zero1;
   logic             take;

   // A coin leaves the hopper on the handshake cycle.
   assign take = (state_q == DISPENSE) && bus.hopper_ready;

   coin_inventory_counter #(.CNT_W(CNT_W), .INIT(INIT_CNT10)) u_cnt10 (
      .clk     (clk),
      .reset   (reset),
      .inc_i   (bus.refill && (bus.refill_sel == REFILL_10)),
      .dec_i   (take && (cur_d_q == COIN_10)),
      .count_o (cnt10),
      .zero_o  (zero10)
   );

   coin_inventory_counter #(.CNT_W(CNT_W), .INIT(INIT_CNT5)) u_cnt5 (
      .clk     (clk),
      .reset   (reset),
      .inc_i   (bus.refill && (bus.refill_sel == REFILL_5)),
      .dec_i   (take && (cur_d_q == COIN_5)),
      .count_o (cnt5),
      .zero_o  (zero5)
   );

   coin_inventory_counter #(.CNT_W(CNT_W), .INIT(INIT_CNT1)) u_cnt1 (
      .clk     (clk),
      .reset   (reset),
      .inc_i   (bus.refill && (bus.refill_sel == REFILL_1)),
      .dec_i   (take && (cur_d_q == COIN_1)),
      .count_o (cnt1),
      .zero_o  (zero1)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         cur_d_q     <= '0;
         short_q     <= 1'b0;
         short_amt_q <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         cur_d_q     <= cur_d_d;
         short_q     <= short_d;
         short_amt_q <= short_amt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      cur_d_d     = cur_d_q;
      short_d     = short_q;
      short_amt_d = short_amt_q;

      case (state_q)
         IDLE: begin
            // Shortfall status is held from the last request until a new one starts.
            if (bus.start) begin
               remaining_d = bus.amount;
               short_d     = 1'b0;
               short_amt_d = '0;
               state_d     = SELECT;
            end
         end

         SELECT: begin
            // Checking d <= remaining before selection keeps remaining from underflowing.
            if (remaining_q == '0) begin
               short_d = 1'b0;
               state_d = DONE;
            end else if ((remaining_q >= COIN_10) && (cnt10 != '0)) begin
               cur_d_d = COIN_10;
               state_d = DISPENSE;
            end else if ((remaining_q >= COIN_5) && (cnt5 != '0)) begin
               cur_d_d = COIN_5;
               state_d = DISPENSE;
            end else if ((remaining_q >= COIN_1) && (cnt1 != '0)) begin
               cur_d_d = COIN_1;
               state_d = DISPENSE;
            end else begin
               short_d     = 1'b1;
               short_amt_d = remaining_q;
               state_d     = DONE;
            end
         end

         DISPENSE: begin
            // cur_d stays fixed here; a refill is only considered at the next SELECT.
            if (bus.hopper_ready) begin
               remaining_d = remaining_q - cur_d_q;
               state_d     = SELECT;
            end
         end

         DONE:    state_d = IDLE;

         default: state_d = IDLE;
      endcase
   end

   assign bus.coin_valid = (state_q == DISPENSE);
   assign bus.coin_value = (state_q == DISPENSE) ? cur_d_q : 8'd0;
   assign bus.busy       = (state_q != IDLE);
   assign bus.done       = (state_q == DONE);
   assign bus.short      = short_q;
   assign bus.short_amt  = short_amt_q;
   assign bus.inv_empty  = {zero10, zero5, zero1};

endmodule

// File: tb/tb_change_dispenser_ctrl.sv
// Table-driven bench for change_dispenser_ctrl plus hand-written sequences
// for stalls, reset mid-request, refill collisions and counter saturation.
// Three instances cover default inventory, no 5-dollar coins and no
// 1-dollar coins; "sel" routes stimulus and observation to one of them.
module tb_change_dispenser_ctrl;
   import vending_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic       start_drv = 1'b0;
   logic [7:0] amount_drv = '0;
   logic       hopper_ready_drv = 1'b0;
   logic       refill_drv = 1'b0;
   logic [1:0] refill_sel_drv = '0;
   int         sel = 0;

   int checks = 0;
   int errors = 0;

   change_dispenser_ctrl_if bus0 ();
   change_dispenser_ctrl_if bus1 ();
   change_dispenser_ctrl_if bus2 ();

   assign bus0.start        = start_drv && (sel == 0);
   assign bus1.start        = start_drv && (sel == 1);
   assign bus2.start        = start_drv && (sel == 2);
   assign bus0.amount       = amount_drv;
   assign bus1.amount       = amount_drv;
   assign bus2.amount       = amount_drv;
   assign bus0.hopper_ready = hopper_ready_drv;
   assign bus1.hopper_ready = hopper_ready_drv;
   assign bus2.hopper_ready = hopper_ready_drv;
   assign bus0.refill       = refill_drv;
   assign bus1.refill       = 1'b0;
   assign bus2.refill       = 1'b0;
   assign bus0.refill_sel   = refill_sel_drv;
   assign bus1.refill_sel   = refill_sel_drv;
   assign bus2.refill_sel   = refill_sel_drv;

   change_dispenser_ctrl dut0 (.clk(clk), .reset(reset), .bus(bus0));
   change_dispenser_ctrl #(.INIT_CNT5(0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
   change_dispenser_ctrl #(.INIT_CNT1(0)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

   logic       obs_valid, obs_busy, obs_done, obs_short;
   logic [7:0] obs_value, obs_short_amt, obs_c10, obs_c5, obs_c1;
   logic [2:0] obs_inv;

   always_comb begin
      obs_valid = bus0.coin_valid;  obs_value = bus0.coin_value;
      obs_busy  = bus0.busy;        obs_done  = bus0.done;
      obs_short = bus0.short;       obs_short_amt = bus0.short_amt;
      obs_inv   = bus0.inv_empty;
      obs_c10   = dut0.cnt10;       obs_c5 = dut0.cnt5;  obs_c1 = dut0.cnt1;
      case (sel)
         1: begin
            obs_valid = bus1.coin_valid;  obs_value = bus1.coin_value;
            obs_busy  = bus1.busy;        obs_done  = bus1.done;
            obs_short = bus1.short;       obs_short_amt = bus1.short_amt;
            obs_inv   = bus1.inv_empty;
            obs_c10   = dut1.cnt10;       obs_c5 = dut1.cnt5;  obs_c1 = dut1.cnt1;
         end
         2: begin
            obs_valid = bus2.coin_valid;  obs_value = bus2.coin_value;
            obs_busy  = bus2.busy;        obs_done  = bus2.done;
            obs_short = bus2.short;       obs_short_amt = bus2.short_amt;
            obs_inv   = bus2.inv_empty;
            obs_c10   = dut2.cnt10;       obs_c5 = dut2.cnt5;  obs_c1 = dut2.cnt1;
         end
         default: ;
      endcase
   end

   // Coin sequence is packed one byte per coin, first coin in the low byte.
   typedef struct {
      int           sel;
      logic [7:0]   amount;
      int           n_coins;
      logic [127:0] seq;
      int           cycles;
      logic         short_e;
      logic [7:0]   short_amt_e;
      logic [7:0]   c10, c5, c1;
      logic [2:0]   inv;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      start_drv = 1'b0;
      refill_drv = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int cyc;
      cyc = 0;
      while (!obs_done && cyc < 100) begin
         tick();
         cyc++;
      end
      check({name, " done reached"}, obs_done, 1);
   endtask

   task automatic run_vector(input vec_t v, input int idx);
      logic [127:0] got;
      int n;
      int cyc;
      got = '0;
      n = 0;
      sel = v.sel;
      amount_drv = v.amount;
      hopper_ready_drv = 1'b1;
      start_drv = 1'b1;
      tick();
      start_drv = 1'b0;
      cyc = 1;
      while (!obs_done && cyc < 200) begin
         if (obs_valid) begin
            if (n < 16) got[8*n +: 8] = obs_value;
            n++;
         end
         tick();
         cyc++;
      end
      if (!obs_done) begin
         checks++;
         errors++;
         $display("FAIL v%0d timeout: got no done after %0d cycles, expected done at %0d", idx, cyc, v.cycles);
      end else begin
         check($sformatf("v%0d coin count", idx), n, v.n_coins);
         for (int i = 0; i < v.n_coins && i < 16; i++)
            check($sformatf("v%0d coin[%0d]", idx, i), got[8*i +: 8], v.seq[8*i +: 8]);
         check($sformatf("v%0d done latency", idx), cyc, v.cycles);
         check($sformatf("v%0d short", idx), obs_short, v.short_e);
         check($sformatf("v%0d short_amt", idx), obs_short_amt, v.short_amt_e);
         check($sformatf("v%0d cnt10", idx), obs_c10, v.c10);
         check($sformatf("v%0d cnt5", idx), obs_c5, v.c5);
         check($sformatf("v%0d cnt1", idx), obs_c1, v.c1);
         check($sformatf("v%0d inv_empty", idx), obs_inv, v.inv);
      end
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit seen_done;

      // Cumulative on the default instance: 8/8/8 coins at reset.
      vecs[0] = '{sel:0, amount:8'd6,   n_coins:2,  seq:128'h0105,
                  cycles:6,  short_e:1'b0, short_amt_e:8'd0,
                  c10:8'd8, c5:8'd7, c1:8'd7, inv:3'b000};
      vecs[1] = '{sel:0, amount:8'd26,  n_coins:4,  seq:128'h0105_0a0a,
                  cycles:10, short_e:1'b0, short_amt_e:8'd0,
                  c10:8'd6, c5:8'd6, c1:8'd6, inv:3'b000};
      vecs[2] = '{sel:0, amount:8'd0,   n_coins:0,  seq:128'h0,
                  cycles:2,  short_e:1'b0, short_amt_e:8'd0,
                  c10:8'd6, c5:8'd6, c1:8'd6, inv:3'b000};
      vecs[3] = '{sel:0, amount:8'd15,  n_coins:2,  seq:128'h050a,
                  cycles:6,  short_e:1'b0, short_amt_e:8'd0,
                  c10:8'd5, c5:8'd5, c1:8'd6, inv:3'b000};
      vecs[4] = '{sel:0, amount:8'd9,   n_coins:5,  seq:128'h0101_0101_05,
                  cycles:12, short_e:1'b0, short_amt_e:8'd0,
                  c10:8'd5, c5:8'd4, c1:8'd2, inv:3'b000};
      // Drains everything: 5x10 + 4x5 + 2x1 = 72 paid, 128 short.
      vecs[5] = '{sel:0, amount:8'd200, n_coins:11, seq:128'h0101_0505_0505_0a0a_0a0a_0a,
                  cycles:24, short_e:1'b1, short_amt_e:8'd128,
                  c10:8'd0, c5:8'd0, c1:8'd0, inv:3'b111};
      // No 5-dollar coins: 7 paid in ones.
      vecs[6] = '{sel:1, amount:8'd7,   n_coins:7,  seq:128'h0101_0101_0101_01,
                  cycles:16, short_e:1'b0, short_amt_e:8'd0,
                  c10:8'd8, c5:8'd0, c1:8'd1, inv:3'b010};
      // No 1-dollar coins: nothing can be paid.
      vecs[7] = '{sel:2, amount:8'd3,   n_coins:0,  seq:128'h0,
                  cycles:2,  short_e:1'b1, short_amt_e:8'd3,
                  c10:8'd8, c5:8'd8, c1:8'd0, inv:3'b001};

      // Reset state
      sel = 0;
      do_reset();
      check("rst coin_valid", obs_valid, 0);
      check("rst coin_value", obs_value, 0);
      check("rst busy", obs_busy, 0);
      check("rst done", obs_done, 0);
      check("rst short", obs_short, 0);
      check("rst short_amt", obs_short_amt, 0);
      check("rst inv_empty", obs_inv, 3'b000);
      check("rst cnt10", obs_c10, 8);
      check("rst cnt5", obs_c5, 8);
      check("rst cnt1", obs_c1, 8);

      for (int i = 0; i < 8; i++) run_vector(vecs[i], i);

      // Hopper stall on the first coin of amount 6
      sel = 0;
      do_reset();
      hopper_ready_drv = 1'b0;
      amount_drv = 8'd6;
      start_drv = 1'b1;
      tick();
      start_drv = 1'b0;
      check("stall select busy", obs_busy, 1);
      tick();
      for (int i = 0; i < 3; i++) begin
         check($sformatf("stall[%0d] coin_valid", i), obs_valid, 1);
         check($sformatf("stall[%0d] coin_value", i), obs_value, 5);
         check($sformatf("stall[%0d] cnt5", i), obs_c5, 8);
         tick();
      end
      hopper_ready_drv = 1'b1;
      check("stall release coin_valid", obs_valid, 1);
      check("stall release coin_value", obs_value, 5);
      tick();
      check("stall single decrement", obs_c5, 7);
      check("stall back in select", obs_valid, 0);
      wait_done("stall");
      check("stall short", obs_short, 0);
      check("stall cnt1", obs_c1, 7);
      tick();

      // Reset while the 5-dollar coin of amount 15 is presented
      do_reset();
      hopper_ready_drv = 1'b1;
      amount_drv = 8'd15;
      start_drv = 1'b1;
      tick();
      start_drv = 1'b0;
      tick();
      check("abort first coin", obs_value, 10);
      tick();
      check("abort cnt10 after handshake", obs_c10, 7);
      tick();
      check("abort second coin", obs_value, 5);
      hopper_ready_drv = 1'b0;
      reset = 1'b1;
      tick();
      check("abort coin_valid", obs_valid, 0);
      check("abort busy", obs_busy, 0);
      check("abort done", obs_done, 0);
      check("abort cnt10", obs_c10, 8);
      check("abort cnt5", obs_c5, 8);
      reset = 1'b0;
      seen_done = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (obs_done) seen_done = 1'b1;
         tick();
      end
      check("abort no done pulse", seen_done, 0);
      check("abort idle busy", obs_busy, 0);

      // Refill of tens during a 10-coin handshake; start while busy ignored
      do_reset();
      hopper_ready_drv = 1'b1;
      amount_drv = 8'd10;
      start_drv = 1'b1;
      tick();
      start_drv = 1'b0;
      tick();
      check("collide coin_value", obs_value, 10);
      refill_drv = 1'b1;
      refill_sel_drv = REFILL_10;
      tick();
      refill_drv = 1'b0;
      check("collide cnt10 net zero", obs_c10, 8);
      amount_drv = 8'd5;
      start_drv = 1'b1;
      tick();
      start_drv = 1'b0;
      check("collide done", obs_done, 1);
      check("collide short", obs_short, 0);
      tick();
      for (int i = 0; i < 3; i++) begin
         check($sformatf("ignored start busy[%0d]", i), obs_busy, 0);
         check($sformatf("ignored start coin_valid[%0d]", i), obs_valid, 0);
         tick();
      end
      check("ignored start cnt5", obs_c5, 8);

      // Refill saturation and the ignored selector code
      refill_drv = 1'b1;
      refill_sel_drv = REFILL_1;
      repeat (250) tick();
      refill_drv = 1'b0;
      check("saturate cnt1", obs_c1, 255);
      refill_drv = 1'b1;
      refill_sel_drv = 2'd3;
      repeat (3) tick();
      refill_drv = 1'b0;
      check("sel3 cnt10", obs_c10, 8);
      check("sel3 cnt5", obs_c5, 8);
      check("sel3 cnt1", obs_c1, 255);
      refill_drv = 1'b1;
      refill_sel_drv = REFILL_5;
      tick();
      refill_drv = 1'b0;
      check("refill cnt5", obs_c5, 9);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
